peridot_romdata_arbiter: RTL and testbench
==========================================

// Module: peridot_romdata_arbiter
// PURPOSE
//  Shares the 32-byte board serial-rom byte port (byteaddr/bytedata, 'J7W' header + UID ASCII) between two requesters.
//  Req0: host-side stream reader, which sequentially reads bytes 0..STREAM_LEN-1 with a valid/ack handshake.
//  Req1: Avalon-MM slave for random single-byte reads.
//  Sits between the rom contents block and the host bridge / CSR fabric; holds off all access until the rom reports ready.
// PARAMETERS
//  STREAM_LEN      26  number of bytes in one host stream (1..32)
//  FIXED_PRIORITY  0   0 = round-robin per byte; 1 = Req0 always wins
// PORTS
//  clk              in   1  single clock, rising edge
//  reset            in   1  synchronous, active-high
//  rom_ready        in   1  rom contents valid (UID settled)
//  rom_byteaddr     out  5  byte address to rom (combinational data return)
//  rom_bytedata     in   8  byte data from rom
//  host_start       in   1  1-cycle pulse: begin stream from byte 0
//  host_busy        out  1  stream in progress
//  host_data        out  8  stream byte
//  host_valid       out  1  host_data valid; held until host_ack
//  host_ack         in   1  consumer accepts host_data
//  host_done        out  1  1-cycle pulse after last byte acked
//  avs_address      in   5  byte address
//  avs_read         in   1  read request
//  avs_waitrequest  out  1  stall
//  avs_readdata     out  8  read data, valid with avs_waitrequest=0
// BEHAVIOUR
//  Reset values: rom_byteaddr=0, host_busy=0, host_valid=0, host_data=0, host_done=0, avs_waitrequest=1, avs_readdata=0.
//  FSM:
//   IDLE --(rom_ready & pending req)--> ADDR --> CAPT --(grant=0)--> HOLD / --(grant=1)--> IDLE.
//   HOLD --host_ack--> IDLE.
//  IDLE: arbitrate among pending Req0 (host_busy & ~host_valid) and Req1 (avs_read).
//   Round-robin: the last-granted requester loses a tie.
//  ADDR: rom_byteaddr <= granted address (Req0: stream index; Req1: avs_address).
//  CAPT: capture rom_bytedata.
//   Req0: host_data, host_valid=1, go to HOLD.
//   Req1: avs_readdata, avs_waitrequest=0 for exactly this cycle.
//  Latency: Req1 uncontended = 3 cycles from avs_read to waitrequest low. Req0 byte visible 3 cycles after grant.
//  avs_waitrequest is 1 in every other cycle; avs_address must be held while stalled (Avalon rule).
//  host_start while busy: ignored. host_start with rom_ready=0: latched, and the stream starts when ready.
//  Stream index: 5-bit counter, increments on host_ack.
//   On host_ack of index STREAM_LEN-1: host_busy=0, host_done=1 for 1 cycle, index=0.
//  host_ack while host_valid=0: ignored.
//  rom_ready falling mid-transfer: the current ADDR/CAPT completes; no new grants until rom_ready=1.
//  Addresses >= 26 return whatever the rom returns (0xFF); no address checks here.
//  Reset mid-stream: all state to reset values, and the stream is abandoned (no host_done).
// CONFIGURATION
//  `PERIDOT_ROMARB_CHECKSUM_EN defined:
//   Stream gains one extra trailing byte = 8-bit modular sum of the STREAM_LEN bytes, two's-complemented.
//   (sum of all STREAM_LEN+1 bytes == 0x00).
//   The sum accumulates on each host_ack and clears on host_start. host_done follows the checksum byte ack.
//   Req1 is unaffected.
//  Not defined: stream is exactly STREAM_LEN bytes; no accumulator logic is built.
// STRUCTURE
//  Package peridot_romarb_pkg:
//   FSM state encoding (IDLE, ADDR, CAPT, HOLD).
//   Requester index constants (REQ_HOST=0, REQ_AVS=1).
//   ROM_ADDR_W=5.
//  Sub-module peridot_romarb_rr2: 2-way round-robin grant (req[1:0], last, gnt[1:0]), combinational.
//  Everything else is flat in this module.
// TESTING
//  1. rom_ready=0, avs_read=1 addr 0 for 20 cycles -> avs_waitrequest stays 1.
//     Raise rom_ready -> readdata 0x4A ('J') 3 cycles later.
//  2. host_start, ack each byte immediately, UID 0x0123456789ABCDEF, GENCODE 0x4E
//     -> bytes 4A 37 57 02 4A 37 32 4E 39 33 30 31 ... 46, then host_done after the 26th ack.
//  3. Same as 2 with avs_read addr 3 held constantly -> host bytes and Req1 grants alternate.
//     Every avs read returns 0x02. Host stream is still correct.
//  4. Host delays host_ack 10 cycles per byte -> host_data/host_valid stable throughout.
//     Req1 reads serviced during HOLD.
//  5. Assert reset at stream byte 12 -> host_busy=0, host_valid=0, no host_done.
//     Restart streams from 0x4A.
//  6. With `PERIDOT_ROMARB_CHECKSUM_EN, stream of 2 -> 27th byte makes the 27-byte sum 0x00 mod 256.
//     Without the macro -> exactly 26 bytes.

Source files
------------

// File: rtl/peridot_romarb_pkg.sv
// Shared definitions for the serial-rom byte-port arbiter: FSM states,
// requester indices, rom address width and a checksum helper.
package peridot_romarb_pkg;

    localparam int ROM_ADDR_W = 5;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_AVS  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_CAPT = 2'd2,
        ST_HOLD = 2'd3
    } arb_state_e;

    // Two's complement of an 8-bit running sum, so that the whole stream sums to zero
    function automatic logic [7:0] twos_neg8(input logic [7:0] value);
        return 8'h00 - value;
    endfunction

endpackage

// File: rtl/peridot_romarb_rr2.sv
// Two-way round-robin grant: on a tie the requester granted last time loses.
module peridot_romarb_rr2
    import peridot_romarb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // One-hot grant; a single requester always wins, a tie goes to the one not granted last
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            if (last == REQ_HOST) begin
                gnt = 2'b10;
            end else begin
                gnt = 2'b01;
            end
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/peridot_romdata_arbiter.sv
// Shares the 32-byte serial-rom byte port between the host stream reader
// (Req0) and an Avalon-MM single-byte reader (Req1). No access is granted
// until the rom reports ready; a transfer already in flight always completes.
// A stream byte stays presented while the host sits on it, and the Avalon
// side may be serviced meanwhile (HOLD is left early for a pending Req1).
// Build macro PERIDOT_ROMARB_CHECKSUM_EN appends a two's-complement checksum
// byte to every host stream.
module peridot_romdata_arbiter
    import peridot_romarb_pkg::*;
#(
    parameter int STREAM_LEN     = 26,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rom_ready,
    output logic [ROM_ADDR_W-1:0] rom_byteaddr,
    input  logic [7:0]            rom_bytedata,
    input  logic                  host_start,
    output logic                  host_busy,
    output logic [7:0]            host_data,
    output logic                  host_valid,
    input  logic                  host_ack,
    output logic                  host_done,
    input  logic [ROM_ADDR_W-1:0] avs_address,
    input  logic                  avs_read,
    output logic                  avs_waitrequest,
    output logic [7:0]            avs_readdata
);

`ifdef PERIDOT_ROMARB_CHECKSUM_EN
    localparam int STREAM_TOTAL = STREAM_LEN + 1;
`else
    localparam int STREAM_TOTAL = STREAM_LEN;
`endif
    localparam logic [5:0] LAST_IDX = 6'(STREAM_TOTAL - 1);

    arb_state_e state_r;
    arb_state_e next_s;
    logic       last_r;
    logic       owner_r;
    logic [5:0] idx_r;
    logic [1:0] req_s;
    logic [1:0] gnt_s;
    logic       last_eff_s;
    logic [7:0] byte_s;

    // Req1 is masked in its completion cycle so a held avs_read is not granted twice
    assign req_s      = {avs_read & avs_waitrequest, host_busy & ~host_valid};
    assign last_eff_s = (FIXED_PRIORITY != 0) ? REQ_AVS : last_r;

    peridot_romarb_rr2 u_rr2 (
        .req  (req_s),
        .last (last_eff_s),
        .gnt  (gnt_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state: grant only while the rom is ready; HOLD yields early to a waiting Avalon read
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rom_ready && (gnt_s != 2'b00)) begin
                    next_s = ST_ADDR;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_ADDR: next_s = ST_CAPT;
            ST_CAPT: begin
                if (owner_r == REQ_HOST) begin
                    next_s = ST_HOLD;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (host_ack || !host_valid || req_s[1]) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_HOLD;
                end
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // Remember who owns the current transfer and who won the last arbitration
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r <= REQ_HOST;
            last_r  <= REQ_AVS;
        end else if ((state_r == ST_IDLE) && (next_s == ST_ADDR)) begin
            owner_r <= gnt_s[1] ? REQ_AVS : REQ_HOST;
            last_r  <= gnt_s[1] ? REQ_AVS : REQ_HOST;
        end else begin
            owner_r <= owner_r;
            last_r  <= last_r;
        end
    end

    // Rom byte address, loaded for the granted requester in ADDR
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_byteaddr <= 5'd0;
        end else if (state_r == ST_ADDR) begin
            rom_byteaddr <= (owner_r == REQ_AVS) ? avs_address : idx_r[4:0];
        end else begin
            rom_byteaddr <= rom_byteaddr;
        end
    end

    // Avalon response: data captured in CAPT, waitrequest low for exactly one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            avs_waitrequest <= 1'b1;
            avs_readdata    <= 8'h00;
        end else if ((state_r == ST_CAPT) && (owner_r == REQ_AVS)) begin
            avs_waitrequest <= 1'b0;
            avs_readdata    <= rom_bytedata;
        end else begin
            avs_waitrequest <= 1'b1;
            avs_readdata    <= avs_readdata;
        end
    end

    // Host stream: start, byte presentation, acknowledge and end-of-stream pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            host_busy  <= 1'b0;
            host_valid <= 1'b0;
            host_data  <= 8'h00;
            host_done  <= 1'b0;
            idx_r      <= 6'd0;
        end else begin
            host_done <= 1'b0;
            if ((state_r == ST_CAPT) && (owner_r == REQ_HOST)) begin
                host_data  <= byte_s;
                host_valid <= 1'b1;
            end else if (host_valid && host_ack) begin
                host_valid <= 1'b0;
                if (idx_r == LAST_IDX) begin
                    host_busy <= 1'b0;
                    host_done <= 1'b1;
                    idx_r     <= 6'd0;
                end else begin
                    idx_r <= idx_r + 6'd1;
                end
            end else if (host_start && !host_busy) begin
                host_busy <= 1'b1;
                idx_r     <= 6'd0;
            end else begin
                host_busy <= host_busy;
            end
        end
    end

`ifdef PERIDOT_ROMARB_CHECKSUM_EN
    logic [7:0] sum_r;

    // Running sum of acknowledged stream bytes, cleared when a new stream starts
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_r <= 8'h00;
        end else if (host_start && !host_busy) begin
            sum_r <= 8'h00;
        end else if (host_valid && host_ack) begin
            sum_r <= sum_r + host_data;
        end else begin
            sum_r <= sum_r;
        end
    end

    // The trailing stream byte is the negated sum instead of rom data
    always_comb begin
        if (idx_r == 6'(STREAM_LEN)) begin
            byte_s = twos_neg8(sum_r);
        end else begin
            byte_s = rom_bytedata;
        end
    end
`else
    assign byte_s = rom_bytedata;
`endif

endmodule

// File: tb/tb_peridot_romdata_arbiter.sv
// Self-checking bench for peridot_romdata_arbiter: directed scenarios plus a
// randomized phase, all checked by a transaction-level model of the host
// stream and the Avalon read port.
module tb_peridot_romdata_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       rom_ready;
    logic [4:0] rom_byteaddr;
    logic [7:0] rom_bytedata;
    logic       host_start;
    logic       host_busy;
    logic [7:0] host_data;
    logic       host_valid;
    logic       host_ack;
    logic       host_done;
    logic [4:0] avs_address;
    logic       avs_read;
    logic       avs_waitrequest;
    logic [7:0] avs_readdata;

    logic [7:0] rom_mem [0:31];

`ifdef PERIDOT_ROMARB_CHECKSUM_EN
    localparam int TOTAL_BYTES = 27;
`else
    localparam int TOTAL_BYTES = 26;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    assign rom_bytedata = rom_mem[rom_byteaddr];

    peridot_romdata_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .rom_ready       (rom_ready),
        .rom_byteaddr    (rom_byteaddr),
        .rom_bytedata    (rom_bytedata),
        .host_start      (host_start),
        .host_busy       (host_busy),
        .host_data       (host_data),
        .host_valid      (host_valid),
        .host_ack        (host_ack),
        .host_done       (host_done),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_waitrequest (avs_waitrequest),
        .avs_readdata    (avs_readdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model + compare process ----------------
    logic [7:0] got_q [$];
    int         done_seen = 0;
    int         avs_done_cnt = 0;

    function automatic logic [7:0] exp_byte(input int idx, input logic [7:0] s);
        if (idx < 26) return rom_mem[idx];
        return 8'h00 - s;
    endfunction

    initial begin
        bit         m_busy;
        bit         old_busy;
        bit         exp_done;
        int         m_idx;
        logic [7:0] m_sum;
        logic       pv_valid;
        logic       pv_wr;
        logic [7:0] pv_data;
        int         avs_wait;
        int         host_wait;
        m_busy = 1'b0; m_idx = 0; m_sum = 8'h00;
        pv_valid = 1'b0; pv_wr = 1'b1; pv_data = 8'h00;
        avs_wait = 0; host_wait = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                m_busy = 1'b0; m_idx = 0; m_sum = 8'h00;
                avs_wait = 0; host_wait = 0;
                chk("rst_busy",  32'(host_busy),       32'(1'b0));
                chk("rst_valid", 32'(host_valid),      32'(1'b0));
                chk("rst_data",  32'(host_data),       32'h00);
                chk("rst_done",  32'(host_done),       32'(1'b0));
                chk("rst_wr",    32'(avs_waitrequest), 32'(1'b1));
                chk("rst_rdata", 32'(avs_readdata),    32'h00);
                chk("rst_addr",  32'(rom_byteaddr),    32'h00);
            end else begin
                exp_done = 1'b0;
                old_busy = m_busy;
                if (pv_valid && host_ack) begin
                    got_q.push_back(pv_data);
                    m_sum = m_sum + exp_byte(m_idx, m_sum);
                    m_idx++;
                    if (m_idx == TOTAL_BYTES) begin
                        m_busy = 1'b0; m_idx = 0; exp_done = 1'b1;
                    end
                end
                if (host_start && !old_busy) begin
                    m_busy = 1'b1; m_idx = 0; m_sum = 8'h00;
                end
                chk("busy", 32'(host_busy), 32'(m_busy));
                chk("done", 32'(host_done), 32'(exp_done));
                if (host_done) done_seen++;
                if (pv_valid && !host_ack) begin
                    chk("hold_valid", 32'(host_valid), 32'(1'b1));
                    chk("hold_data",  32'(host_data),  32'(pv_data));
                end else if (host_valid) begin
                    chk("stream_byte", 32'(host_data), 32'(exp_byte(m_idx, m_sum)));
                end
                if (!m_busy) chk("valid_idle", 32'(host_valid), 32'(1'b0));
                if (!avs_waitrequest) begin
                    chk("avs_data",   32'(avs_readdata), 32'(rom_mem[avs_address]));
                    chk("avs_single", 32'(pv_wr),        32'(1'b1));
                    avs_done_cnt++;
                end
                if (rom_ready && avs_read && avs_waitrequest) avs_wait++; else avs_wait = 0;
                if (rom_ready && host_busy && !host_valid) host_wait++; else host_wait = 0;
                if (avs_wait > 0)  chk("avs_stall_bound",  32'(avs_wait > 12),  32'(1'b0));
                if (host_wait > 0) chk("host_stall_bound", 32'(host_wait > 12), 32'(1'b0));
            end
            pv_valid = host_valid; pv_wr = avs_waitrequest; pv_data = host_data;
        end
    end

    // ---------------- host acknowledge driver ----------------
    int ack_delay = 0;
    bit rand_ack  = 1'b0;
    bit junk_ack  = 1'b0;

    initial begin
        bit ack_armed;
        int ack_cnt;
        int cur_delay;
        ack_armed = 1'b0; ack_cnt = 0; cur_delay = 0;
        host_ack = 1'b0;
        forever begin
            @(negedge clk);
            host_ack = 1'b0;
            if (host_valid) begin
                if (!ack_armed) begin
                    ack_armed = 1'b1; ack_cnt = 0;
                    cur_delay = rand_ack ? int'($urandom_range(0, 6)) : ack_delay;
                end
                if (ack_cnt >= cur_delay) begin
                    host_ack = 1'b1; ack_armed = 1'b0;
                end else begin
                    ack_cnt++;
                end
            end else begin
                ack_armed = 1'b0;
                if (junk_ack && ($urandom_range(0, 3) == 0)) host_ack = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_stream();
        host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0;
        int n;
        d0 = done_seen; n = 0;
        while ((done_seen == d0) && (n < 4000)) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(done_seen - d0), 32'd1);
    endtask

    task automatic avs_do(input logic [4:0] a, output logic [7:0] d, output bit ok);
        int n;
        n = 0;
        avs_address = a;
        avs_read = 1'b1;
        @(negedge clk);
        while (avs_waitrequest && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        ok = !avs_waitrequest;
        d = avs_readdata;
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    bit t_stop = 1'b0;

    initial begin
        int         base;
        int         n;
        int         lat;
        int         hi_cnt;
        int         cnt;
        int         d0;
        logic [7:0] s;
        for (int i = 0; i < 32; i++) rom_mem[i] = 8'hFF;
        rom_mem[0] = 8'h4A; rom_mem[1] = 8'h37; rom_mem[2] = 8'h57; rom_mem[3] = 8'h02;
        rom_mem[4] = 8'h4A; rom_mem[5] = 8'h37; rom_mem[6] = 8'h32; rom_mem[7] = 8'h4E;
        rom_mem[8] = 8'h39; rom_mem[9] = 8'h33;
        for (int i = 0; i < 16; i++) rom_mem[10 + i] = (i < 10) ? 8'(8'h30 + i) : 8'(8'h41 + i - 10);

        reset = 1'b1; rom_ready = 1'b0; host_start = 1'b0;
        avs_read = 1'b0; avs_address = 5'd0;
        repeat (3) @(negedge clk);
        chk("reset_wr_literal", 32'(avs_waitrequest), 32'(1'b1));
        reset = 1'b0;

        // 1: no grants while the rom is not ready, then 3-cycle read latency
        avs_address = 5'd0; avs_read = 1'b1; hi_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (avs_waitrequest) hi_cnt++;
        end
        chk("t1_stall_not_ready", 32'(hi_cnt), 32'd20);
        rom_ready = 1'b1; lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (avs_waitrequest && (lat < 20));
        chk("t1_latency", 32'(lat), 32'd3);
        chk("t1_data", 32'(avs_readdata), 32'h4A);
        @(negedge clk);
        avs_read = 1'b0;
        repeat (2) @(negedge clk);

        // 2: full stream, immediate acks
        base = got_q.size();
        start_stream();
        wait_done("t2_done");
        n = got_q.size() - base;
        chk("t2_len", 32'(n), 32'(TOTAL_BYTES));
        if (n >= 26) begin
            chk("t2_b0",  32'(got_q[base]),      32'h4A);
            chk("t2_b3",  32'(got_q[base + 3]),  32'h02);
            chk("t2_b7",  32'(got_q[base + 7]),  32'h4E);
            chk("t2_b11", 32'(got_q[base + 11]), 32'h31);
            chk("t2_b25", 32'(got_q[base + 25]), 32'h46);
        end
`ifdef PERIDOT_ROMARB_CHECKSUM_EN
        if (n == 27) begin
            s = 8'h00;
            for (int i = 0; i < 27; i++) s = s + got_q[base + i];
            chk("t2_checksum_sum", 32'(s), 32'h00);
        end
`endif
        repeat (3) @(negedge clk);

        // 3: stream with a constantly held Avalon read of address 3
        t_stop = 1'b0; cnt = 0;
        fork
            begin
                start_stream();
                wait_done("t3_done");
                t_stop = 1'b1;
            end
            begin
                logic [7:0] dd;
                bit         okk;
                while (!t_stop) begin
                    avs_do(5'd3, dd, okk);
                    chk("t3_avs_ok", 32'(okk), 32'(1'b1));
                    chk("t3_avs_data", 32'(dd), 32'h02);
                    cnt++;
                end
            end
        join
        chk("t3_alternate", 32'(cnt >= 20), 32'(1'b1));
        repeat (3) @(negedge clk);

        // 4: slow host acks, Avalon reads serviced while a byte is held
        ack_delay = 10; t_stop = 1'b0; cnt = 0;
        fork
            begin
                start_stream();
                wait_done("t4_done");
                t_stop = 1'b1;
            end
            begin
                logic [7:0] dd;
                bit         okk;
                while (!t_stop) begin
                    avs_do(5'($urandom_range(0, 31)), dd, okk);
                    chk("t4_avs_ok", 32'(okk), 32'(1'b1));
                    cnt++;
                end
            end
        join
        chk("t4_avs_during_hold", 32'(cnt >= 20), 32'(1'b1));
        ack_delay = 0;
        repeat (3) @(negedge clk);

        // 5: reset at stream byte 12, then a clean restart
        base = got_q.size(); n = 0;
        start_stream();
        while (((got_q.size() - base) < 12) && (n < 1000)) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_12", 32'(got_q.size() - base), 32'd12);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("t5_busy_cleared", 32'(host_busy), 32'(1'b0));
        chk("t5_valid_cleared", 32'(host_valid), 32'(1'b0));
        d0 = done_seen;
        repeat (40) @(negedge clk);
        chk("t5_no_done", 32'(done_seen - d0), 32'd0);
        base = got_q.size();
        start_stream();
        wait_done("t5_restart_done");
        chk("t5_restart_len", 32'(got_q.size() - base), 32'(TOTAL_BYTES));
        if (got_q.size() > base) chk("t5_restart_b0", 32'(got_q[base]), 32'h4A);

        // 6: randomized traffic, rom_ready toggling, stray acks and starts
        rand_ack = 1'b1; junk_ack = 1'b1; t_stop = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                    start_stream();
                    repeat ($urandom_range(5, 30)) @(negedge clk);
                    if (host_busy) start_stream();
                    wait_done("rand_done");
                end
                t_stop = 1'b1;
            end
            begin
                while (!t_stop) begin
                    repeat ($urandom_range(5, 40)) @(negedge clk);
                    rom_ready = 1'b0;
                    repeat ($urandom_range(1, 8)) @(negedge clk);
                    rom_ready = 1'b1;
                end
            end
            begin
                logic [7:0] dd;
                bit         okk;
                while (!t_stop) begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    avs_do(5'($urandom_range(0, 31)), dd, okk);
                    chk("rand_avs_ok", 32'(okk), 32'(1'b1));
                end
            end
        join
        rand_ack = 1'b0; junk_ack = 1'b0;
        repeat (5) @(negedge clk);
        chk("avs_reads_seen", 32'(avs_done_cnt > 50), 32'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
